bcd_display_scanner: RTL

//  Sequencer for a shared 7-segment datapath: splits a 4-bit binary value (0-15) into tens/ones
//  BCD digits and time-multiplexes them onto one segment bus with per-digit anode enables.

---
 rtl/bcd_disp_pkg.sv | 30 +++
 rtl/bcd_display_scanner_if.sv | 13 +
 rtl/seg7_encoder.sv | 12 +
 rtl/bcd_display_scanner.sv | 118 +++++++++++
 4 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared types and constants for the BCD display scanner: scan states, blanking codes, digit segment table.
// Pure declarations; no logic, no latency, no flow control.
package bcd_disp_pkg;

  typedef enum logic [1:0] {
    S_ONES = 2'd0,
    S_GAP0 = 2'd1,
    S_TENS = 2'd2,
    S_GAP1 = 2'd3
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;
  localparam logic [3:0] AN_ONES   = 4'b1110;
  localparam logic [3:0] AN_TENS   = 4'b1101;

  // Active-low {g,f,e,d,c,b,a}; entry 0 is the rightmost element, codes 10-15 are blank.
  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK,
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // Returns {tens, ones} for a 0-15 binary value.
  function automatic logic [7:0] bcd_split(input logic [3:0] v);
    logic [3:0] tens;
    tens = (v >= 4'd10) ? 4'd1 : 4'd0;
    return {tens, v - ((tens == 4'd1) ? 4'd10 : 4'd0)};
  endfunction

endpackage

// File: rtl/bcd_display_scanner_if.sv
// Display bus between the value producer and the scanner: load strobe/value in, anode/segment pins out.
// No handshake: load is a fire-and-forget strobe; display pins are free-running.
interface bcd_display_scanner_if;
  logic       load;
  logic [3:0] value;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_upd;

  modport master (output load, value, input an, seg, dp, frame_upd);
  modport slave  (input load, value, output an, seg, dp, frame_upd);
endinterface

// File: rtl/seg7_encoder.sv
// Combinational BCD digit to active-low 7-segment code; codes above 9 render blank.
// Zero latency, no flow control.
module seg7_encoder
  import bcd_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[bcd];

endmodule

// File: rtl/bcd_display_scanner.sv
// Two-digit 7-seg scanner with blank gaps; values commit only at frame start. Outputs lag state by 1 cycle.
// No backpressure: latest load wins. Define LEADING_ZERO_BLANK_EN to leave the tens anode dark for 0-9.
module bcd_display_scanner
  import bcd_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int GAP_DIV     = 1000,
  parameter int CNT_W       = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  bcd_display_scanner_if.slave  disp
);

  localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_DIV - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       pending_q, pending_d;
  logic             pend_vld_q, pend_vld_d;
  logic [3:0]       active_q, active_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             frame_upd_q, frame_upd_d;

  logic [3:0] tens, ones, digit;
  logic [6:0] digit_seg;
  logic       slot_last;

  assign {tens, ones} = bcd_split(active_q);
  assign digit        = (state_q == S_TENS) ? tens : ones;

  seg7_encoder u_enc (
    .bcd (digit),
    .seg (digit_seg)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    pending_d   = pending_q;
    pend_vld_d  = pend_vld_q;
    active_d    = active_q;
    frame_upd_d = 1'b0;
    an_d        = AN_OFF;
    seg_d       = SEG_BLANK;
    slot_last   = ((state_q == S_ONES) || (state_q == S_TENS)) ? (cnt_q == REF_LAST)
                                                               : (cnt_q == GAP_LAST);

    if (slot_last) begin
      cnt_d = '0;
      case (state_q)
        S_ONES: state_d = S_GAP0;
        S_GAP0: state_d = S_TENS;
        S_TENS: state_d = S_GAP1;
        S_GAP1: begin
          state_d = S_ONES;
          if (pend_vld_q) begin
            active_d    = pending_q;
            pend_vld_d  = 1'b0;
            frame_upd_d = 1'b1;
          end
        end
      endcase
    end

    // A load on the commit cycle overrides the clear above, so it waits for the next frame.
    if (disp.load) begin
      pending_d  = disp.value;
      pend_vld_d = 1'b1;
    end

    case (state_q)
      S_ONES: begin
        an_d  = AN_ONES;
        seg_d = digit_seg;
      end
      S_TENS: begin
        seg_d = digit_seg;
`ifdef LEADING_ZERO_BLANK_EN
        an_d  = (tens == 4'd0) ? AN_OFF : AN_TENS;
`else
        an_d  = AN_TENS;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_ONES;
      cnt_q       <= '0;
      pending_q   <= '0;
      pend_vld_q  <= 1'b0;
      active_q    <= '0;
      an_q        <= AN_OFF;
      seg_q       <= SEG_BLANK;
      frame_upd_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      pend_vld_q  <= pend_vld_d;
      active_q    <= active_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      frame_upd_q <= frame_upd_d;
    end
  end

  assign disp.an        = an_q;
  assign disp.seg       = seg_q;
  assign disp.dp        = 1'b1;
  assign disp.frame_upd = frame_upd_q;

endmodule
